// File: rtl/i2s_pkg.sv
// -----------------------------------------------------------------------------
// i2s_pkg
// Shared definitions for the i2s_tx_stream transmitter.
//   fmt_e        : serial format encoding carried on the 2-bit fmt port
//   params_legal : elaboration-time legality check of the transmitter geometry
// -----------------------------------------------------------------------------
package i2s_pkg;

    typedef enum logic [1:0] {
        FMT_I2S     = 2'd0,
        FMT_LJ      = 2'd1,
        FMT_RJ      = 2'd2,
        FMT_I2S_ALT = 2'd3   // reserved code, behaves exactly like FMT_I2S
    } fmt_e;

    // Sample must fit in its slot, the divider needs a low and a high phase,
    // and the FIFO pointers rely on natural wrap of a power-of-two depth.
    function automatic bit params_legal(input int sample_w, input int slot_w,
                                        input int bclk_div, input int fifo_depth);
        return (sample_w >= 1) && (sample_w <= slot_w) && (bclk_div >= 2) &&
               (fifo_depth >= 2) && ((fifo_depth & (fifo_depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/i2s_tx_stream_sample_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo
// Synchronous FIFO holding stereo sample pairs. Not fall-through: a word pushed
// at edge T is first visible (empty deasserted, dout valid) after edge T.
// Simultaneous push and pop are both honoured and leave level unchanged.
//   clk, resetn : system clock, asynchronous active-low reset
//   push, din   : write request (ignored when full) and write data
//   pop, dout   : read request (ignored when empty) and head-of-queue data
//   empty, full : registered status flags
//   level       : registered number of entries held (0..DEPTH)
// -----------------------------------------------------------------------------
module sample_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;
    logic [PTR_W:0]    level_next;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_comb begin
        level_next = level;
        if (do_push && !do_pop) begin
            level_next = level + 1'b1;
        end else if (do_pop && !do_push) begin
            level_next = level - 1'b1;
        end
    end

    // NOTE: the storage array has no reset; contents are meaningless until
    // written, and the pointer/level reset alone discards everything held.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level_next;
            empty <= (level_next == '0);
            full  <= (level_next == (PTR_W + 1)'(DEPTH));
        end
    end

endmodule

// File: rtl/i2s_tx_stream.sv
// -----------------------------------------------------------------------------
// i2s_tx_stream
// Stereo I2S / left-justified / right-justified serial transmitter with an
// internal sample-pair FIFO and a built-in BCLK divider.
//   clk            : system clock (clk_384 domain)
//   resetn         : asynchronous active-low reset
//   in_valid/ready : sample-pair handshake; in_ready is low only when full
//   in_left/right  : two's complement samples, SAMPLE_W bits
//   fmt            : 0 I2S, 1 LJ, 2 RJ, 3 I2S; latched at each frame start
//   underrun_mute  : on an empty FIFO at frame start, 1 plays zeros, 0 repeats
//   bclk/lrclk     : bit clock and word select (0 = left slot)
//   sdata          : serial data, MSB first, changes on bclk falling edge
//   underrun       : one-cycle pulse per frame started with an empty FIFO
//   fifo_level     : entries currently held
// -----------------------------------------------------------------------------
module i2s_tx_stream
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W   = 24,
    parameter int SLOT_W     = 32,
    parameter int BCLK_DIV   = 25,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SAMPLE_W-1:0]           in_left,
    input  logic [SAMPLE_W-1:0]           in_right,
    input  logic [1:0]                    fmt,
    input  logic                          underrun_mute,
    output logic                          bclk,
    output logic                          lrclk,
    output logic                          sdata,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    if (!params_legal(SAMPLE_W, SLOT_W, BCLK_DIV, FIFO_DEPTH)) begin : g_param_check
        $error("i2s_tx_stream: illegal SAMPLE_W/SLOT_W/BCLK_DIV/FIFO_DEPTH combination");
    end

    localparam int FRAME_W = 2 * SLOT_W;
    localparam int C_W     = $clog2(BCLK_DIV);
    localparam int B_W     = $clog2(FRAME_W);
    localparam int HALF    = (BCLK_DIV + 1) / 2;   // bclk low for the first ceil(DIV/2) counts
    localparam int RJ_OFS  = SLOT_W - SAMPLE_W;    // leading zero bits of an RJ slot
    localparam int PAIR_W  = 2 * SAMPLE_W;

    localparam logic [C_W-1:0] C_LAST = C_W'(BCLK_DIV - 1);
    localparam logic [B_W-1:0] B_LAST = B_W'(FRAME_W - 1);

    // Divider / bit counter state. Reset values make the first edge after
    // reset release a frame start.
    logic [C_W-1:0]    c_q;
    logic [C_W-1:0]    c_next;
    logic [B_W-1:0]    b_q;
    logic [B_W-1:0]    b_next;
    logic              bit_start;
    logic              frame_start;

    // Current pair {left, right}, frame format and the one-bit I2S delay.
    logic [PAIR_W-1:0] pair_q;
    logic [PAIR_W-1:0] pair_next;
    fmt_e              fmt_q;
    fmt_e              fmt_next;
    logic              i2s_dly_q;

    // FIFO interface
    logic [PAIR_W-1:0] fifo_dout;
    logic              fifo_empty;
    logic              fifo_full;

    // Bit selection for the bit period that starts at the coming edge
    logic              slot_right;
    logic [SAMPLE_W-1:0] sample;
    logic [SAMPLE_W-1:0] lj_word;
    logic [SAMPLE_W-1:0] rj_word;
    int                pos;
    int                rj_shift;
    logic              lj_bit;
    logic              rj_bit;
    logic              sdata_next;

    sample_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (in_valid),
        .din    ({in_left, in_right}),
        .pop    (frame_start),
        .dout   (fifo_dout),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .level  (fifo_level)
    );

    assign in_ready    = !fifo_full;
    assign bit_start   = (c_q == C_LAST);
    assign frame_start = bit_start && (b_q == B_LAST);
    assign c_next      = bit_start ? '0 : c_q + C_W'(1);
    assign b_next      = !bit_start ? b_q : (frame_start ? '0 : b_q + B_W'(1));

    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        fmt_next  = fmt_q;
        pair_next = pair_q;
        if (frame_start) begin
            fmt_next = fmt_e'(fmt);
            if (!fifo_empty) begin
                pair_next = fifo_dout;
            end else if (underrun_mute) begin
                pair_next = '0;
            end
        end

        slot_right = (b_next >= B_W'(SLOT_W));
        pos        = slot_right ? int'(b_next) - SLOT_W : int'(b_next);
        sample     = slot_right ? pair_next[SAMPLE_W-1:0] : pair_next[PAIR_W-1 -: SAMPLE_W];

        // Shifting the wanted bit up to the MSB avoids a variable bit index;
        // positions past the sample shift everything out and yield 0.
        lj_word  = sample << pos;
        lj_bit   = lj_word[SAMPLE_W-1];
        rj_shift = (pos >= RJ_OFS) ? pos - RJ_OFS : 0;
        rj_word  = sample << rj_shift;
        rj_bit   = (pos >= RJ_OFS) ? rj_word[SAMPLE_W-1] : 1'b0;

        case (fmt_next)
            FMT_LJ:  sdata_next = lj_bit;
            FMT_RJ:  sdata_next = rj_bit;
            default: sdata_next = i2s_dly_q;   // I2S: LJ stream one bit late
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            c_q       <= C_LAST;
            b_q       <= B_LAST;
            bclk      <= 1'b0;
            lrclk     <= 1'b0;
            sdata     <= 1'b0;
            underrun  <= 1'b0;
            i2s_dly_q <= 1'b0;
            pair_q    <= '0;
            fmt_q     <= FMT_I2S;
        end else begin
            c_q      <= c_next;
            bclk     <= (int'(c_next) >= HALF);
            underrun <= frame_start && fifo_empty;
            if (bit_start) begin
                b_q       <= b_next;
                lrclk     <= slot_right;
                sdata     <= sdata_next;
                // The delay always tracks the LJ stream, so switching into I2S
                // replays the last LJ bit of the previous frame.
                i2s_dly_q <= lj_bit;
            end
            if (frame_start) begin
                pair_q <= pair_next;
                fmt_q  <= fmt_next;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_stream.sv
// -----------------------------------------------------------------------------
// tb_i2s_tx_stream
// Directed bench for i2s_tx_stream (SAMPLE_W=24, SLOT_W=32, BCLK_DIV=4,
// FIFO_DEPTH=4). The stimulus process queues the hand-computed 64-bit frame
// image (bit b of the frame at vector position 63-b) and underrun count for
// every frame; the monitor rebuilds frames from sdata at bclk rising edges and
// compares them against the queue.
// -----------------------------------------------------------------------------
module tb_i2s_tx_stream;

    localparam int SAMPLE_W   = 24;
    localparam int SLOT_W     = 32;
    localparam int BCLK_DIV   = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int FRAME_CYC  = 2 * SLOT_W * BCLK_DIV;

    localparam logic [63:0] LR_EXP   = 64'h00000000_FFFFFFFF;
    localparam logic [63:0] ZERO_FR  = 64'h0;
    localparam logic [63:0] A_LJ     = 64'hABCDEF00_12345600;
    localparam logic [63:0] A_I2S    = 64'h55E6F780_091A2B00;
    localparam logic [63:0] A_RJ     = 64'h00ABCDEF_00123456;
    localparam logic [63:0] B_RJ     = 64'h00800001_007FFFFF;

    logic                clk = 1'b0;
    logic                resetn;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [SAMPLE_W-1:0] in_left  = '0;
    logic [SAMPLE_W-1:0] in_right = '0;
    logic [1:0]          fmt = 2'd1;
    logic                underrun_mute = 1'b1;
    logic                bclk;
    logic                lrclk;
    logic                sdata;
    logic                underrun;
    logic [2:0]          fifo_level;

    always #5 clk = ~clk;

    i2s_tx_stream #(
        .SAMPLE_W   (SAMPLE_W),
        .SLOT_W     (SLOT_W),
        .BCLK_DIV   (BCLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_left       (in_left),
        .in_right      (in_right),
        .fmt           (fmt),
        .underrun_mute (underrun_mute),
        .bclk          (bclk),
        .lrclk         (lrclk),
        .sdata         (sdata),
        .underrun      (underrun),
        .fifo_level    (fifo_level)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [63:0] bits;
        int          ur;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    task automatic expect_frame(input string name, input logic [63:0] bits, input int ur);
        exp_t e;
        e.bits = bits;
        e.ur   = ur;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Edge counter: frame k starts at the edge where edge_n becomes 1 + k*FRAME_CYC
    int edge_n;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) edge_n <= 0;
        else         edge_n <= edge_n + 1;
    end

    function automatic int fs(input int k);
        return 1 + k * FRAME_CYC;
    endfunction

    task automatic goto_edge(input int n);
        while (edge_n < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_pair(input logic [SAMPLE_W-1:0] l, input logic [SAMPLE_W-1:0] r);
        in_left  = l;
        in_right = r;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // ---------------- monitor ----------------
    logic        mon_en = 1'b0;
    int          frames_seen = 0;
    logic        m_prev_bclk = 1'b0;
    logic        m_prev_lr = 1'b1;
    int          m_idx = 64;
    logic [63:0] m_bits = '0;
    logic [63:0] m_lrs = '0;
    int          m_ur_cnt = 0;
    int          m_frame_ur = 0;
    int          m_cyc = 0;
    int          m_hi = 0;
    int          m_clk_bad = 0;
    bit          m_seen_rise = 1'b0;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (underrun) m_ur_cnt++;
                m_cyc++;
                if (bclk) m_hi++;
                if (!bclk && m_prev_bclk) begin
                    if (m_hi != BCLK_DIV / 2) m_clk_bad++;
                    m_hi = 0;
                end
                if (bclk && !m_prev_bclk) begin
                    if (m_seen_rise && m_cyc != BCLK_DIV) m_clk_bad++;
                    m_seen_rise = 1'b1;
                    m_cyc = 0;
                    if (!lrclk && m_prev_lr) begin
                        m_idx = 0;
                        m_frame_ur = m_ur_cnt;
                        m_ur_cnt = 0;
                    end
                    m_prev_lr = lrclk;
                    if (m_idx < 64) begin
                        m_bits[63 - m_idx] = sdata;
                        m_lrs[63 - m_idx]  = lrclk;
                        m_idx++;
                        if (m_idx == 64) begin
                            frames_seen++;
                            if (exp_q.size() == 0) begin
                                total++;
                                bad++;
                                $display("FAIL unexpected_frame: got frame %0d, required none", frames_seen);
                            end else begin
                                e = exp_q.pop_front();
                                check({e.name, "_sdata"}, m_bits, e.bits);
                                check({e.name, "_lrclk"}, m_lrs, LR_EXP);
                                check({e.name, "_underrun"}, 64'(m_frame_ur), 64'(e.ur));
                                check({e.name, "_bclk_timing"}, 64'(m_clk_bad), 64'd0);
                            end
                            m_clk_bad = 0;
                        end
                    end
                end
                m_prev_bclk = bclk;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached, bench did not complete");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        bit done;
        resetn = 1'b0;
        #22;
        check("rst_bclk",       64'(bclk),       64'd0);
        check("rst_lrclk",      64'(lrclk),      64'd0);
        check("rst_sdata",      64'(sdata),      64'd0);
        check("rst_underrun",   64'(underrun),   64'd0);
        check("rst_in_ready",   64'(in_ready),   64'd1);
        check("rst_fifo_level", 64'(fifo_level), 64'd0);

        @(negedge clk);
        resetn = 1'b1;
        mon_en = 1'b1;

        // Idle frames with mute: zeros and one underrun each
        expect_frame("f0_idle", ZERO_FR, 1);
        expect_frame("f1_idle", ZERO_FR, 1);
        expect_frame("f2_idle", ZERO_FR, 1);

        goto_edge(fs(2) + 128);
        fmt = 2'd1;
        push_pair(24'hABCDEF, 24'h123456);
        expect_frame("f3_lj", A_LJ, 0);

        goto_edge(fs(3) + 128);
        fmt = 2'd0;
        push_pair(24'hABCDEF, 24'h123456);
        expect_frame("f4_i2s", A_I2S, 0);

        goto_edge(fs(4) + 128);
        fmt = 2'd2;
        push_pair(24'hABCDEF, 24'h123456);
        expect_frame("f5_rj", A_RJ, 0);

        goto_edge(fs(5) + 128);
        fmt = 2'd1;
        underrun_mute = 1'b0;
        push_pair(24'hABCDEF, 24'h123456);
        expect_frame("f6_lj", A_LJ, 0);
        expect_frame("f7_repeat", A_LJ, 1);

        goto_edge(fs(7) + 128);
        underrun_mute = 1'b1;
        expect_frame("f8_mute", ZERO_FR, 1);

        goto_edge(fs(8) + 128);
        fmt = 2'd2;
        push_pair(24'h800001, 24'h7FFFFF);
        expect_frame("f9_rj_fmt_hold", B_RJ, 0);

        // Mid-frame format change only takes effect at the next frame start
        goto_edge(fs(9) + 20);
        fmt = 2'd1;
        expect_frame("f10_empty", ZERO_FR, 1);

        // Fill the FIFO and try one push beyond full
        goto_edge(fs(10) + 128);
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       push_pair(24'h111111, 24'h222222);
                1:       push_pair(24'h333333, 24'h444444);
                2:       push_pair(24'hFFFFFF, 24'h000001);
                default: push_pair(24'h5A5A5A, 24'hA5A5A5);
            endcase
            check($sformatf("fill_level_%0d", i), 64'(fifo_level), 64'(i + 1));
            check($sformatf("fill_ready_%0d", i), 64'(in_ready), (i < 3) ? 64'd1 : 64'd0);
        end
        push_pair(24'h777777, 24'h777777);
        check("overfull_level", 64'(fifo_level), 64'd4);
        check("overfull_ready", 64'(in_ready), 64'd0);

        expect_frame("f11_c0", 64'h11111100_22222200, 0);
        expect_frame("f12_c1", 64'h33333300_44444400, 0);
        expect_frame("f13_c2", 64'hFFFFFF00_00000100, 0);
        expect_frame("f14_c3", 64'h5A5A5A00_A5A5A500, 0);
        expect_frame("f15_drained", ZERO_FR, 1);

        goto_edge(fs(11) - 1);
        check("prepop_level", 64'(fifo_level), 64'd4);
        goto_edge(fs(11));
        check("postpop_level", 64'(fifo_level), 64'd3);
        goto_edge(fs(11) + 1);
        check("postpop_ready", 64'(in_ready), 64'd1);

        // Wait for the monitor to consume every queued frame
        done = 1'b0;
        for (int i = 0; i < 6 * FRAME_CYC && !done; i++) begin
            @(posedge clk);
            #1;
            if (frames_seen >= 16 && exp_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL frame_timeout: got %0d frames, required 16 (queue left %0d)",
                     frames_seen, exp_q.size());
        end
        mon_en = 1'b0;

        // Asynchronous reset in the right slot with an entry held
        goto_edge(fs(16) + 180);
        push_pair(24'h123123, 24'h456456);
        check("pre_reset_level", 64'(fifo_level), 64'd1);
        check("pre_reset_lrclk", 64'(lrclk), 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_bclk",     64'(bclk),       64'd0);
        check("async_rst_lrclk",    64'(lrclk),      64'd0);
        check("async_rst_sdata",    64'(sdata),      64'd0);
        check("async_rst_underrun", 64'(underrun),   64'd0);
        check("async_rst_ready",    64'(in_ready),   64'd1);
        check("async_rst_level",    64'(fifo_level), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2s_tx_stream.md
# i2s_tx_stream

Parametrised stereo I2S/left-/right-justified serial transmitter with an internal sample FIFO, a valid/ready input and a built-in BCLK divider. It sits between the S/PDIF decode/mix path and the output pins. It generalises the fixed 16-bit, left-only transmitter with width, slot, format, buffering and underrun-policy control. All outputs are registered in the single system clock domain.

## Interface
- SAMPLE_W, 24: sample width in bits; must be ≤ SLOT_W.
- SLOT_W, 32: BCLK periods per channel slot; frame = 2·SLOT_W bits.
- BCLK_DIV, 25: clk cycles per BCLK period; must be ≥ 2.
- FIFO_DEPTH, 4: stereo entries; power of two, ≥ 2.

- clk  in  1  system clock (clk_384 domain)
- resetn  in  1  asynchronous, active-low reset
- in_valid  in  1  sample pair offered
- in_ready  out  1  FIFO not full
- in_left  in  SAMPLE_W  left sample, two's complement
- in_right  in  SAMPLE_W  right sample, two's complement
- fmt  in  2  0 = I2S, 1 = left-justified (LJ), 2 = right-justified (RJ), 3 = treated as I2S
- underrun_mute  in  1  1: play zeros on underrun; 0: repeat last pair
- bclk  out  1  bit clock
- lrclk  out  1  0 = left slot, 1 = right slot
- sdata  out  1  serial data, MSB first
- underrun  out  1  one-cycle pulse per underrun frame
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held

## Operation
- Push occurs when in_valid && in_ready. in_ready = (fifo_level < FIFO_DEPTH).
- The FIFO is not fall-through. A push and a pop in the same cycle are both honoured; the level is unchanged.
- Divider counter c runs 0..BCLK_DIV-1.
  - bclk = 0 while c < ceil(BCLK_DIV/2), else 1.
  - Each bit period starts when c wraps to 0, which is the bclk falling edge.
- Bit counter b runs 0..2·SLOT_W-1 and advances at each bit start. Frame start is the bit start with b = 0.
- At each frame start:
  - fmt is latched for the whole frame.
  - If the FIFO is non-empty, one pair is popped and becomes the current pair.
  - If the FIFO is empty, underrun pulses for one cycle. The current pair becomes zero if underrun_mute = 1, otherwise it stays unchanged.
- lrclk = (b ≥ SLOT_W) in every format.
- LJ stream, at slot position p = b mod SLOT_W:
  - p < SAMPLE_W: sample bit [SAMPLE_W-1-p].
  - Otherwise: 0.
- RJ stream:
  - p ≥ SLOT_W-SAMPLE_W: sample bit [SLOT_W-1-p].
  - Otherwise: 0.
- I2S: sdata is the LJ stream delayed by exactly one bit period, so the MSB appears one BCLK after the lrclk edge. Bit 0 of a frame carries the LJ bit 2·SLOT_W-1 of the previous frame (0 unless SAMPLE_W = SLOT_W).
- A change of fmt mid-frame has no effect until the next frame start. The I2S delay register is not flushed on a format change.

## Timing
- Reset values:
  - bclk = 0, lrclk = 0, sdata = 0, underrun = 0.
  - in_ready = 1, fifo_level = 0.
  - Current pair and I2S delay bit = 0.
  - c = BCLK_DIV-1 and b = 2·SLOT_W-1, so the first clk edge after reset release is a frame start.
- bclk, lrclk and sdata change on the same clk edge (bit start). The receiver samples on the bclk rising edge, ceil(BCLK_DIV/2) clk cycles later.
- The pop decision uses FIFO state at the frame-start edge T.
  - A push completing at edge T-1 or earlier is played in the frame starting at T.
  - A push completing at edge T is played in the next frame.
- fifo_level and in_ready update on the edge after the push or pop.
- The underrun pulse is high during the cycle after frame-start edge T.
- Asserting resetn mid-frame returns every output to its reset value immediately and discards all FIFO contents.

## Structure
- Package i2s_pkg holds the FMT_I2S / FMT_LJ / FMT_RJ constants and the parameter-legality checks.
- Sub-module sample_fifo holds the FIFO: width 2·SAMPLE_W, depth FIFO_DEPTH, with clk/resetn, push/pop, empty/full/level.
- The top holds the divider, bit counter, shift/selection logic and output registers.

## Test plan
All scenarios use SAMPLE_W=24, SLOT_W=32, BCLK_DIV=4, FIFO_DEPTH=4.
- Reset then idle 3 frames, mute=1 → underrun pulses once per frame; sdata constant 0; bclk period 4 cycles, 2 low and 2 high.
- LJ, push L=0xABCDEF R=0x123456 before a frame start →
  - left bits 0-23 = 0xABCDEF MSB first, bits 24-31 = 0;
  - right bits 32-55 = 0x123456;
  - lrclk rises at b=32.
- I2S, same pair → the pattern is shifted one bit: b=1 carries bit 23 of 0xABCDEF, b=33 carries bit 23 of 0x123456; lrclk is unchanged from LJ.
- RJ, same pair → bits 8-31 = 0xABCDEF, bits 0-7 = 0; bits 40-63 = 0x123456.
- One push, then starvation:
  - mute=0 → the next frame repeats 0xABCDEF/0x123456 with an underrun pulse.
  - mute=1 → the following frame is all zeros.
- Push 5 pairs with no frame start in between → in_ready drops after the 4th push and fifo_level = 4. After the next frame start, fifo_level = 3 and in_ready = 1 one cycle later.
